// File: rtl/ms13_slave_feeder_if.sv
// Bus bundle for ms13_slave_feeder: producer port, the two slave-input channels,
// the downstream master response and the status outputs.
//   slave  : the feeder's view (producer data and responses in, strobes and status out).
//   master : the environment's view (the mirror image).
interface ms13_slave_feeder_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] b_in;
  logic             b_in_sync;
  logic             b_in_notify;
  logic [WIDTH-1:0] s_out_a;
  logic             s_out_a_sync;
  logic [WIDTH-1:0] s_out_b;
  logic             s_out_b_sync;
  logic [WIDTH-1:0] m_in;
  logic             m_in_notify;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             stray_resp;
  logic [CntW-1:0]  count;

  modport slave (
    input  b_in, b_in_sync, m_in, m_in_notify,
    output b_in_notify, s_out_a, s_out_a_sync, s_out_b, s_out_b_sync,
           result, result_valid, stray_resp, count
  );

  modport master (
    output b_in, b_in_sync, m_in, m_in_notify,
    input  b_in_notify, s_out_a, s_out_a_sync, s_out_b, s_out_b_sync,
           result, result_valid, stray_resp, count
  );
endinterface

// File: rtl/ms13_slave_feeder.sv
// ms13_slave_feeder: buffers producer words in a DEPTH-entry FIFO and issues them
// in pairs (A channel, then B channel), then waits for one downstream response
// before issuing the next pair. At most one pair is in flight.
// Ports:
//   clk  : clock, rising edge.
//   rst  : asynchronous active-low reset.
//   bus  : slave modport of ms13_slave_feeder_if (producer in, A/B strobes out,
//          response in, result/result_valid/stray_resp/count out).
module ms13_slave_feeder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  ms13_slave_feeder_if.slave   bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StSendA, StSendB, StWaitResp} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] s_out_a_q;
  logic             s_out_a_sync_q;
  logic [WIDTH-1:0] s_out_b_q;
  logic             s_out_b_sync_q;
  logic [WIDTH-1:0] result_q;
  logic             result_valid_q;
  logic             stray_resp_q;

  logic full;
  logic push;
  logic pop;

  // Full is judged on the registered count, so a pop in the same cycle never
  // lets a push through.
  assign full = (count_q == FullCnt);
  assign push = bus.b_in_sync && !full;
  assign pop  = (state_q != StWaitResp) && (count_q != '0);

  assign bus.b_in_notify  = push;
  assign bus.count        = count_q;
  assign bus.s_out_a      = s_out_a_q;
  assign bus.s_out_a_sync = s_out_a_sync_q;
  assign bus.s_out_b      = s_out_b_q;
  assign bus.s_out_b_sync = s_out_b_sync_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.stray_resp   = stray_resp_q;

  // Storage needs no reset: occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.b_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StSendA;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      s_out_a_q      <= '0;
      s_out_a_sync_q <= 1'b0;
      s_out_b_q      <= '0;
      s_out_b_sync_q <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      stray_resp_q   <= 1'b0;
    end else begin
      s_out_a_sync_q <= 1'b0;
      s_out_b_sync_q <= 1'b0;
      result_valid_q <= 1'b0;

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // A response while a pair is still being issued is a protocol error;
      // it is flagged but otherwise ignored.
      if (bus.m_in_notify && (state_q != StWaitResp)) begin
        stray_resp_q <= 1'b1;
      end

      unique case (state_q)
        StSendA: begin
          if (pop) begin
            s_out_a_q      <= mem_q[rd_ptr_q];
            s_out_a_sync_q <= 1'b1;
            state_q        <= StSendB;
          end
        end
        StSendB: begin
          if (pop) begin
            s_out_b_q      <= mem_q[rd_ptr_q];
            s_out_b_sync_q <= 1'b1;
            state_q        <= StWaitResp;
          end
        end
        StWaitResp: begin
          if (bus.m_in_notify) begin
            result_q       <= bus.m_in;
            result_valid_q <= 1'b1;
            state_q        <= StSendA;
          end
        end
        default: state_q <= StSendA;
      endcase
    end
  end

endmodule

// File: tb/tb_ms13_slave_feeder.sv
// Self-checking bench for ms13_slave_feeder: a directed vector table, hand-written
// corner sequences and a randomized run, all checked against a queue-based model.
module tb_ms13_slave_feeder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic clk;
  logic rst;

  ms13_slave_feeder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ms13_slave_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: words waiting in the buffer, and how many words of the current pair
  // have gone out (2 means the pair is complete and a response is awaited).
  logic [31:0] mq[$];
  int          issued;
  logic [31:0] m_a, m_b, m_res;
  bit          m_asy, m_bsy, m_rv, m_stray;

  typedef struct {
    bit          s;
    logic [31:0] d;
    bit          mn;
    logic [31:0] md;
    bit          e_asy;
    logic [31:0] e_a;
    bit          e_bsy;
    logic [31:0] e_b;
    bit          e_rv;
    logic [31:0] e_res;
    bit          e_stray;
    int          e_cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    issued  = 0;
    m_a     = '0;
    m_b     = '0;
    m_res   = '0;
    m_asy   = 0;
    m_bsy   = 0;
    m_rv    = 0;
    m_stray = 0;
  endtask

  task automatic check_model();
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("s_out_a_sync", 32'(bus.s_out_a_sync), 32'(m_asy));
    chk("s_out_a", bus.s_out_a, m_a);
    chk("s_out_b_sync", 32'(bus.s_out_b_sync), 32'(m_bsy));
    chk("s_out_b", bus.s_out_b, m_b);
    chk("result_valid", 32'(bus.result_valid), 32'(m_rv));
    chk("result", bus.result, m_res);
    chk("stray_resp", 32'(bus.stray_resp), 32'(m_stray));
  endtask

  // Called at posedge+1; drives one cycle of inputs, checks the combinational
  // accept, advances the model across the edge, then checks every output.
  task automatic step(input bit s, input logic [31:0] d, input bit mn, input logic [31:0] md);
    bit exp_notify;
    logic [31:0] w;
    bus.b_in_sync   = s;
    bus.b_in        = d;
    bus.m_in_notify = mn;
    bus.m_in        = md;
    #1;
    exp_notify = s && (mq.size() < DEPTH);
    chk("b_in_notify", 32'(bus.b_in_notify), 32'(exp_notify));
    m_asy = 0;
    m_bsy = 0;
    m_rv  = 0;
    if (mn && issued < 2) m_stray = 1;
    if (issued < 2 && mq.size() > 0) begin
      w = mq.pop_front();
      if (issued == 0) begin
        m_a   = w;
        m_asy = 1;
      end else begin
        m_b   = w;
        m_bsy = 1;
      end
      issued++;
    end else if (issued == 2 && mn) begin
      m_res  = md;
      m_rv   = 1;
      issued = 0;
    end
    if (exp_notify) mq.push_back(d);
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Asserts reset between edges; outputs must clear at once.
  task automatic do_reset();
    bus.b_in_sync   = 1'b0;
    bus.b_in        = '0;
    bus.m_in_notify = 1'b0;
    bus.m_in        = '0;
    rst = 1'b0;
    #1;
    model_clear();
    check_model();
    chk("rst_b_in_notify", 32'(bus.b_in_notify), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1, 'hA,  0, 0,     0, 0,     0, 0,  0, 0,     0, 1};
    tbl[1] = '{1, 'hB,  0, 0,     1, 'hA,   0, 0,  0, 0,     0, 1};
    tbl[2] = '{0, 0,    0, 0,     0, 'hA,   1, 'hB, 0, 0,    0, 0};
    tbl[3] = '{0, 0,    0, 0,     0, 'hA,   0, 'hB, 0, 0,    0, 0};
    tbl[4] = '{0, 0,    1, 'h55,  0, 'hA,   0, 'hB, 1, 'h55, 0, 0};
    tbl[5] = '{0, 0,    0, 0,     0, 'hA,   0, 'hB, 0, 'h55, 0, 0};
    tbl[6] = '{1, 'h11, 0, 0,     0, 'hA,   0, 'hB, 0, 'h55, 0, 1};
    tbl[7] = '{0, 0,    0, 0,     1, 'h11,  0, 'hB, 0, 'h55, 0, 0};
    tbl[8] = '{0, 0,    0, 0,     0, 'h11,  0, 'hB, 0, 'h55, 0, 0};
    tbl[9] = '{0, 0,    1, 'h77,  0, 'h11,  0, 'hB, 0, 'h55, 1, 0};

    rst = 1'b1;
    #2;
    do_reset();

    // Directed vector table: pair + response, then a lone word stuck in SEND_B,
    // then a stray response there.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].s, tbl[i].d, tbl[i].mn, tbl[i].md);
      chk($sformatf("tbl%0d_a_sync", i), 32'(bus.s_out_a_sync), 32'(tbl[i].e_asy));
      chk($sformatf("tbl%0d_a", i), bus.s_out_a, tbl[i].e_a);
      chk($sformatf("tbl%0d_b_sync", i), 32'(bus.s_out_b_sync), 32'(tbl[i].e_bsy));
      chk($sformatf("tbl%0d_b", i), bus.s_out_b, tbl[i].e_b);
      chk($sformatf("tbl%0d_rv", i), 32'(bus.result_valid), 32'(tbl[i].e_rv));
      chk($sformatf("tbl%0d_result", i), bus.result, tbl[i].e_res);
      chk($sformatf("tbl%0d_stray", i), 32'(bus.stray_resp), 32'(tbl[i].e_stray));
      chk($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
    end

    // Stray response in SEND_A: flag set, result untouched, A still issues next.
    do_reset();
    step(0, 0, 1, 'h77);
    chk("stray_sendA", 32'(bus.stray_resp), 32'd1);
    chk("stray_result", bus.result, 32'd0);
    step(1, 'h12, 0, 0);
    step(0, 0, 0, 0);
    chk("stray_then_a", bus.s_out_a, 32'h12);
    chk("stray_sticky", 32'(bus.stray_resp), 32'd1);

    // Fill to DEPTH with the response held off, then drain across the wrap.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 32'h100 + 32'(i), 0, 0);
    chk("full_peak", 32'(bus.count), 32'd4);
    step(1, 'h200, 0, 0);
    chk("full_hold", 32'(bus.count), 32'd4);
    for (int r = 0; r < 4; r++) begin
      step(0, 0, 1, 32'h500 + 32'(r));
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    chk("drained", 32'(bus.count), 32'd0);

    // Reset while waiting for a response with three words buffered.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 32'h300 + 32'(i), 0, 0);
    chk("pre_reset_count", 32'(bus.count), 32'd3);
    #3;
    do_reset();
    step(1, 'h31, 0, 0);
    step(1, 'h32, 0, 0);
    chk("post_reset_a", bus.s_out_a, 32'h31);
    step(0, 0, 0, 0);
    chk("post_reset_b", bus.s_out_b, 32'h32);

    // Push and pop on the same edge with count=2 in SEND_A.
    step(1, 'h41, 0, 0);
    step(1, 'h42, 0, 0);
    step(0, 0, 1, 'h99);
    step(1, 'h43, 0, 0);
    chk("pp_count", 32'(bus.count), 32'd2);
    chk("pp_a", bus.s_out_a, 32'h41);

    // Randomized traffic against the model, with the odd reset thrown in.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2;
        do_reset();
      end
      step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 25, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
